// File: rtl/l2_input_sched_pkg.sv
// Shared types and MSHR sizing for the L2 input scheduler.
package l2_input_sched_pkg;

  localparam int N_MSHR       = 4;
  localparam int MSHR_BITS_P1 = $clog2(N_MSHR + 1);

  typedef enum logic [1:0] {
    SEL_RSP = 2'd0,
    SEL_FWD = 2'd1,
    SEL_REQ = 2'd2
  } l2_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MSHR,
    DRAIN,
    DONE
  } l2_fence_state_t;

endpackage

// File: rtl/l2_fence_fsm.sv
// Fence sequencer: waits for all MSHRs to free, optionally drains, then
// pulses the ongoing_fence/ongoing_drain set/clear triggers.
module l2_fence_fsm
  import l2_input_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fence_accept,
  input  logic                    fence_rel,
  input  logic [MSHR_BITS_P1-1:0] mshr_cnt,
  input  logic                    drain_done,
  output logic                    idle,
  output logic                    set_ongoing_fence,
  output logic                    clr_ongoing_fence,
  output logic                    set_ongoing_drain,
  output logic                    clr_ongoing_drain,
  output logic                    fence_done
);

  l2_fence_state_t state, state_nxt;
  logic            rel_q;
  logic            mshr_all_free;

  assign mshr_all_free = (mshr_cnt == MSHR_BITS_P1'(N_MSHR));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fence_accept) rel_q <= fence_rel;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt         = state;
    idle              = 1'b0;
    set_ongoing_fence = 1'b0;
    clr_ongoing_fence = 1'b0;
    set_ongoing_drain = 1'b0;
    clr_ongoing_drain = 1'b0;
    fence_done        = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (fence_accept) begin
          set_ongoing_fence = 1'b1;
          state_nxt         = WAIT_MSHR;
        end
      end
      WAIT_MSHR: begin
        // drain_done arriving on this cycle belongs to no drain we started
        if (mshr_all_free) begin
          set_ongoing_drain = rel_q;
          state_nxt         = rel_q ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          clr_ongoing_drain = 1'b1;
          state_nxt         = DONE;
        end
      end
      DONE: begin
        clr_ongoing_fence = 1'b1;
        fence_done        = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/l2_input_sched.sv
// L2 input scheduler: arbitrates rsp/fwd/req/fence into a one-entry decision
// register, with starvation promotion of CPU requests over forwards.
module l2_input_sched
  import l2_input_sched_pkg::*;
#(
  parameter  int STARVE_MAX = 4,
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    l2_rsp_in_valid,
  output logic                    l2_rsp_in_ready,
  input  logic                    l2_fwd_in_valid,
  output logic                    l2_fwd_in_ready,
  input  logic                    l2_req_in_valid,
  output logic                    l2_req_in_ready,
  input  logic                    l2_fence_valid,
  input  logic                    l2_fence_rel,
  output logic                    l2_fence_ready,
  input  logic                    evict_stall,
  input  logic                    set_conflict,
  input  logic                    fwd_stall,
  input  logic                    fwd_stall_ended,
  input  logic                    ongoing_atomic,
  input  logic [MSHR_BITS_P1-1:0] mshr_cnt,
  input  logic                    drain_done,
  output logic                    dec_valid,
  output logic [1:0]              dec_sel,
  input  logic                    dec_ready,
  output logic                    set_ongoing_fence,
  output logic                    clr_ongoing_fence,
  output logic                    set_ongoing_drain,
  output logic                    clr_ongoing_drain,
  output logic                    fence_done
);

  logic                slot_free;
  logic                fwd_elig;
  logic                req_elig;
  logic                starved;
  logic                fence_idle;
  logic [STARVE_W-1:0] starve_cnt;

  // Readies are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    slot_free       = rst && (!dec_valid || dec_ready);
    fwd_elig        = l2_fwd_in_valid && (!fwd_stall || fwd_stall_ended);
    req_elig        = l2_req_in_valid && (mshr_cnt != '0) && !evict_stall &&
                      !set_conflict && !ongoing_atomic && fence_idle;
    starved         = (starve_cnt == STARVE_W'(STARVE_MAX));
    l2_rsp_in_ready = 1'b0;
    l2_fwd_in_ready = 1'b0;
    l2_req_in_ready = 1'b0;
    l2_fence_ready  = 1'b0;
    if (slot_free) begin
      if (l2_rsp_in_valid)              l2_rsp_in_ready = 1'b1;
      else if (req_elig && starved)     l2_req_in_ready = 1'b1;
      else if (fwd_elig)                l2_fwd_in_ready = 1'b1;
      else if (req_elig)                l2_req_in_ready = 1'b1;
      else if (l2_fence_valid && fence_idle) l2_fence_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_valid <= 1'b0;
      dec_sel   <= SEL_RSP;
    end else if (slot_free) begin
      // A fence grant frees the slot without producing a decode decision.
      dec_valid <= l2_rsp_in_ready || l2_fwd_in_ready || l2_req_in_ready;
      if (l2_rsp_in_ready)      dec_sel <= SEL_RSP;
      else if (l2_fwd_in_ready) dec_sel <= SEL_FWD;
      else if (l2_req_in_ready) dec_sel <= SEL_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!l2_req_in_valid || l2_req_in_ready) begin
      starve_cnt <= '0;
    end else if (l2_fwd_in_ready && req_elig && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  l2_fence_fsm u_fence_fsm (
    .clk               (clk),
    .rst               (rst),
    .fence_accept      (l2_fence_ready),
    .fence_rel         (l2_fence_rel),
    .mshr_cnt          (mshr_cnt),
    .drain_done        (drain_done),
    .idle              (fence_idle),
    .set_ongoing_fence (set_ongoing_fence),
    .clr_ongoing_fence (clr_ongoing_fence),
    .set_ongoing_drain (set_ongoing_drain),
    .clr_ongoing_drain (clr_ongoing_drain),
    .fence_done        (fence_done)
  );

endmodule

// File: tb/tb_l2_input_sched.sv
// Randomized bench for l2_input_sched: a behavioural model predicts grants
// and triggers each cycle; decisions are scoreboarded and checked on consume.
module tb_l2_input_sched;
  import l2_input_sched_pkg::*;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic rsp_valid, fwd_valid, req_valid, fence_valid, fence_rel;
  logic rsp_ready, fwd_ready, req_ready, fence_ready;
  logic evict_stall, set_conflict, fwd_stall, fwd_stall_ended, ongoing_atomic;
  logic [MSHR_BITS_P1-1:0] mshr_cnt;
  logic drain_done, dec_valid, dec_ready;
  logic [1:0] dec_sel;
  logic set_f, clr_f, set_d, clr_d, fence_done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Model state: decision slot occupancy, starvation count, fence progress.
  bit m_occ;
  int m_starve;
  int m_phase;   // 0 no fence, 1 waiting for MSHRs, 2 draining, 3 finishing
  bit m_rel;

  always #5 clk = ~clk;

  l2_input_sched #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .l2_rsp_in_valid(rsp_valid), .l2_rsp_in_ready(rsp_ready),
    .l2_fwd_in_valid(fwd_valid), .l2_fwd_in_ready(fwd_ready),
    .l2_req_in_valid(req_valid), .l2_req_in_ready(req_ready),
    .l2_fence_valid(fence_valid), .l2_fence_rel(fence_rel), .l2_fence_ready(fence_ready),
    .evict_stall(evict_stall), .set_conflict(set_conflict), .fwd_stall(fwd_stall),
    .fwd_stall_ended(fwd_stall_ended), .ongoing_atomic(ongoing_atomic),
    .mshr_cnt(mshr_cnt), .drain_done(drain_done),
    .dec_valid(dec_valid), .dec_sel(dec_sel), .dec_ready(dec_ready),
    .set_ongoing_fence(set_f), .clr_ongoing_fence(clr_f),
    .set_ongoing_drain(set_d), .clr_ongoing_drain(clr_d), .fence_done(fence_done)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rsp_valid = 0; fwd_valid = 0; req_valid = 0; fence_valid = 0; fence_rel = 0;
    evict_stall = 0; set_conflict = 0; fwd_stall = 0; fwd_stall_ended = 0;
    ongoing_atomic = 0; mshr_cnt = MSHR_BITS_P1'(N_MSHR); drain_done = 0; dec_ready = 1;
  endtask

  task automatic randomize_inputs();
    rsp_valid       = ($urandom_range(0, 99) < 25);
    fwd_valid       = ($urandom_range(0, 99) < 55);
    req_valid       = ($urandom_range(0, 99) < 65);
    fence_valid     = ($urandom_range(0, 99) < 15);
    fence_rel       = $urandom_range(0, 1);
    evict_stall     = ($urandom_range(0, 99) < 15);
    set_conflict    = ($urandom_range(0, 99) < 15);
    ongoing_atomic  = ($urandom_range(0, 99) < 10);
    fwd_stall       = ($urandom_range(0, 99) < 30);
    fwd_stall_ended = $urandom_range(0, 1);
    mshr_cnt        = MSHR_BITS_P1'($urandom_range(0, N_MSHR));
    drain_done      = ($urandom_range(0, 99) < 25);
    dec_ready       = ($urandom_range(0, 99) < 70);
  endtask

  // Evaluate the current cycle's inputs against the rules, then advance a cycle.
  task automatic step();
    bit slot, fwd_ok, req_ok, mshr_full;
    int grant;  // 0 none, 1 rsp, 2 fwd, 3 req, 4 fence
    #1;
    mshr_full = (int'(mshr_cnt) == N_MSHR);
    slot   = !m_occ || dec_ready;
    fwd_ok = fwd_valid && (!fwd_stall || fwd_stall_ended);
    req_ok = req_valid && (mshr_cnt != 0) && !evict_stall && !set_conflict &&
             !ongoing_atomic && (m_phase == 0);
    grant = 0;
    if (slot) begin
      if (rsp_valid)                            grant = 1;
      else if (req_ok && m_starve == STARVE_MAX) grant = 3;
      else if (fwd_ok)                          grant = 2;
      else if (req_ok)                          grant = 3;
      else if (fence_valid && m_phase == 0)     grant = 4;
    end
    check("dec_valid", dec_valid, m_occ);
    check("rsp_ready", rsp_ready, grant == 1);
    check("fwd_ready", fwd_ready, grant == 2);
    check("req_ready", req_ready, grant == 3);
    check("fence_ready", fence_ready, grant == 4);
    check("set_ongoing_fence", set_f, grant == 4);
    check("set_ongoing_drain", set_d, m_phase == 1 && mshr_full && m_rel);
    check("clr_ongoing_drain", clr_d, m_phase == 2 && drain_done);
    check("clr_ongoing_fence", clr_f, m_phase == 3);
    check("fence_done", fence_done, m_phase == 3);
    if (grant >= 1 && grant <= 3) exp_q.push_back(grant - 1);

    if (!req_valid || grant == 3) m_starve = 0;
    else if (grant == 2 && req_ok && m_starve < STARVE_MAX) m_starve++;
    if (slot) m_occ = (grant >= 1 && grant <= 3);
    case (m_phase)
      0: if (grant == 4) begin m_phase = 1; m_rel = fence_rel; end
      1: if (mshr_full) m_phase = m_rel ? 2 : 3;
      2: if (drain_done) m_phase = 3;
      default: m_phase = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_sel", dec_sel, SEL_RSP);
    check("rst_readies", {rsp_ready, fwd_ready, req_ready, fence_ready}, 0);
    check("rst_triggers", {set_f, clr_f, set_d, clr_d, fence_done}, 0);
    m_occ = 0; m_starve = 0; m_phase = 0; m_rel = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Monitor: every consumed decision must match the oldest predicted grant.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst && dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          check("dec_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dec_sel", dec_sel, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    do_reset();

    // Priority order with inputs withdrawn as they are accepted.
    rsp_valid = 1; fwd_valid = 1; req_valid = 1; step();
    rsp_valid = 0; step();
    fwd_valid = 0; step();
    req_valid = 0; step();

    // Starvation: forwards keep coming while an eligible request waits.
    fwd_valid = 1; req_valid = 1;
    repeat (7) step();
    clear_inputs(); step();

    // No free MSHR blocks the request, then it is granted immediately.
    req_valid = 1; mshr_cnt = 0;
    repeat (2) step();
    mshr_cnt = 1; step();
    clear_inputs(); step();

    // Release fence: wait on MSHRs, drain, finish; requests blocked throughout.
    fence_valid = 1; fence_rel = 1; mshr_cnt = MSHR_BITS_P1'(N_MSHR - 2); step();
    fence_valid = 0; req_valid = 1; repeat (3) step();
    mshr_cnt = MSHR_BITS_P1'(N_MSHR); drain_done = 1; step();
    drain_done = 0; repeat (2) step();
    drain_done = 1; step();
    drain_done = 0; repeat (3) step();
    clear_inputs(); step();

    // Stalled forward with a held decision, then released.
    rsp_valid = 1; step();
    rsp_valid = 0; dec_ready = 0; fwd_valid = 1; fwd_stall = 1; step();
    step();
    fwd_stall_ended = 1; dec_ready = 1; step();
    clear_inputs(); step();

    // Reset in the middle of a drain, then normal operation resumes.
    fence_valid = 1; fence_rel = 1; step();
    fence_valid = 0; step();
    step();
    drain_done = 1; do_reset();
    clear_inputs(); req_valid = 1; step();
    clear_inputs(); repeat (3) step();

    // Randomized traffic, with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    clear_inputs();
    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
